// File: rtl/cv32e40x_data_resp_tracker_pkg.sv
// Shared types for the data-side response tracker: the OBI data request as seen
// on the bus and the per-transaction tag kept until its response returns.
package cv32e40x_data_resp_tracker_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        bufferable;
  } data_resp_tag_t;

  function automatic data_resp_tag_t make_data_resp_tag(obi_data_req_t trans);
    data_resp_tag_t tag;
    tag.addr       = trans.addr;
    tag.we         = trans.we;
    tag.bufferable = trans.memtype[0];
    return tag;
  endfunction

endpackage

// File: rtl/cv32e40x_data_resp_tracker_sva.sv
// Protocol checks for the response tracker, attached by bind; violations are
// tallied so neighbouring-block misbehaviour is visible without stopping the run.
module cv32e40x_data_resp_tracker_sva #(
  parameter int DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic                       req_valid_i,
  input logic                       req_ready_i,
  input logic                       resp_valid_i,
  input logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  int unsigned push_when_full_cnt  = 0;
  int unsigned resp_when_empty_cnt = 0;

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    (count_o == CNT_W'(DEPTH)) |-> !(req_valid_i && req_ready_i))
    else push_when_full_cnt <= push_when_full_cnt + 1;

  a_no_resp_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    (count_o == '0) |-> !resp_valid_i)
    else resp_when_empty_cnt <= resp_when_empty_cnt + 1;

  c_push_when_full_seen  : cover property (@(posedge clk) push_when_full_cnt != 0);
  c_resp_when_empty_seen : cover property (@(posedge clk) resp_when_empty_cnt != 0);

endmodule

bind cv32e40x_data_resp_tracker cv32e40x_data_resp_tracker_sva #(
  .DEPTH (DEPTH)
) u_sva (
  .clk          (clk),
  .rst_n        (rst_n),
  .req_valid_i  (req_valid_i),
  .req_ready_i  (req_ready_i),
  .resp_valid_i (resp_valid_i),
  .count_o      (count_o)
);

// File: rtl/cv32e40x_resp_tag_fifo.sv
// Small in-order tag FIFO: one entry per outstanding bus transaction, head is
// the tag of the oldest transaction still awaiting its response.
module cv32e40x_resp_tag_fifo
  import cv32e40x_data_resp_tracker_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type TAG_T = data_resp_tag_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  TAG_T                       push_tag_i,
  input  logic                       pop_i,
  output TAG_T                       head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  TAG_T             mem_q [DEPTH];
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Full/empty gating lives here so a misbehaving neighbour cannot corrupt state.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i  && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = next_ptr(wptr_q);
    if (pop_en)  rptr_d = next_ptr(rptr_q);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= push_tag_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cv32e40x_data_resp_tracker.sv
// Tracks outstanding data OBI transactions, tags in-order responses for the LSU
// and turns bus errors on bufferable writes into an imprecise-error pulse.
module cv32e40x_data_resp_tracker
  import cv32e40x_data_resp_tracker_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  input  logic                       req_ready_i,
  input  obi_data_req_t              req_trans_i,
  input  logic                       resp_valid_i,
  input  logic                       resp_err_i,
  input  logic [31:0]                resp_rdata_i,
  output logic                       req_block_o,
  output logic                       resp_valid_o,
  output logic                       resp_err_o,
  output logic [31:0]                resp_rdata_o,
  output logic                       resp_we_o,
  output logic                       resp_bufferable_o,
  output logic                       err_bufferable_o,
  output logic [31:0]                err_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       idle_o
);

  data_resp_tag_t push_tag;
  data_resp_tag_t head;
  logic           full;
  logic           empty;
  logic           pop;
  logic           err_d, err_q;
  logic [31:0]    err_addr_d, err_addr_q;
  logic           unused_trans;

  assign push_tag = make_data_resp_tag(req_trans_i);

  cv32e40x_resp_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_T (data_resp_tag_t)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (req_valid_i && req_ready_i),
    .push_tag_i (push_tag),
    .pop_i      (resp_valid_i),
    .head_o     (head),
    .count_o    (count_o),
    .full_o     (full),
    .empty_o    (empty)
  );

  // A response arriving with nothing outstanding has no owner and is dropped.
  assign pop               = resp_valid_i && !empty;
  assign resp_valid_o      = pop;
  assign resp_err_o        = resp_err_i;
  assign resp_rdata_o      = resp_rdata_i;
  assign resp_we_o         = head.we;
  assign resp_bufferable_o = head.bufferable;

  assign req_block_o = full;
  assign idle_o      = empty;

  always_comb begin
    err_d      = pop && resp_err_i && head.we && head.bufferable;
    err_addr_d = err_d ? head.addr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_bufferable_o = err_q;
  assign err_addr_o       = err_addr_q;

  assign unused_trans = ^{req_trans_i.memtype[1], req_trans_i.prot, req_trans_i.dbg,
                          req_trans_i.be, req_trans_i.wdata, req_trans_i.atop};

endmodule

// File: tb/tb_cv32e40x_data_resp_tracker.sv
// Directed bench for the data response tracker: a vector table for per-cycle
// behaviour plus a hand-written back-to-back bufferable-error sequence.
module tb_cv32e40x_data_resp_tracker;
  import cv32e40x_data_resp_tracker_pkg::*;

  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_i;
  obi_data_req_t req_trans_i;
  logic          resp_valid_i;
  logic          resp_err_i;
  logic [31:0]   resp_rdata_i;
  logic          req_block_o;
  logic          resp_valid_o;
  logic          resp_err_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_we_o;
  logic          resp_bufferable_o;
  logic          err_bufferable_o;
  logic [31:0]   err_addr_o;
  logic [1:0]    count_o;
  logic          idle_o;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  cv32e40x_data_resp_tracker #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_i       (req_ready_i),
    .req_trans_i       (req_trans_i),
    .resp_valid_i      (resp_valid_i),
    .resp_err_i        (resp_err_i),
    .resp_rdata_i      (resp_rdata_i),
    .req_block_o       (req_block_o),
    .resp_valid_o      (resp_valid_o),
    .resp_err_o        (resp_err_o),
    .resp_rdata_o      (resp_rdata_o),
    .resp_we_o         (resp_we_o),
    .resp_bufferable_o (resp_bufferable_o),
    .err_bufferable_o  (err_bufferable_o),
    .err_addr_o        (err_addr_o),
    .count_o           (count_o),
    .idle_o            (idle_o)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic        rr;
    logic [31:0] addr;
    logic        we;
    logic        bf;
    logic        pv;
    logic        pe;
    logic [31:0] rdata;
    logic        eRv;
    logic        eWe;
    logic        eBf;
    int          eCnt;
    logic        eEb;
    logic [31:0] eEa;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rst, input logic rv, input logic rr,
                                 input logic [31:0] addr, input logic we, input logic bf,
                                 input logic pv, input logic pe, input logic [31:0] rdata,
                                 input logic eRv, input logic eWe, input logic eBf,
                                 input int eCnt, input logic eEb, input logic [31:0] eEa);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rr = rr; v.addr = addr; v.we = we; v.bf = bf;
    v.pv = pv; v.pe = pe; v.rdata = rdata;
    v.eRv = eRv; v.eWe = eWe; v.eBf = eBf; v.eCnt = eCnt; v.eEb = eEb; v.eEa = eEa;
    vecs.push_back(v);
  endfunction

  // Drive every DUT input for the coming cycle.
  task automatic applyStimulus(input logic rst, input logic rv, input logic rr,
                               input logic [31:0] addr, input logic we, input logic bf,
                               input logic pv, input logic pe, input logic [31:0] rdata);
    rst_n                = rst;
    req_valid_i          = rv;
    req_ready_i          = rr;
    req_trans_i          = '0;
    req_trans_i.addr     = addr;
    req_trans_i.we       = we;
    req_trans_i.memtype  = {1'b0, bf};
    req_trans_i.be       = 4'hF;
    req_trans_i.wdata    = 32'h5A5A_0000 ^ addr;
    resp_valid_i         = pv;
    resp_err_i           = pe;
    resp_rdata_i         = rdata;
  endtask

  // Compare one observed value with its required value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Registered-state outputs after the most recent edge.
  task automatic checkState(input string tag, input int eCnt, input logic eEb, input logic [31:0] eEa);
    checkOutput({tag, ".count"},     32'(count_o),     32'(eCnt));
    checkOutput({tag, ".req_block"}, 32'(req_block_o), 32'(eCnt == DEPTH));
    checkOutput({tag, ".idle"},      32'(idle_o),      32'(eCnt == 0));
    checkOutput({tag, ".err_buf"},   32'(err_bufferable_o), 32'(eEb));
    checkOutput({tag, ".err_addr"},  err_addr_o,       eEa);
  endtask

  task automatic stepCycle(input logic rv, input logic [31:0] addr, input logic we, input logic bf,
                           input logic pv, input logic pe, input logic [31:0] rdata);
    applyStimulus(1'b1, rv, rv, addr, we, bf, pv, pe, rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst rv rr addr we bf pv pe rdata | eRv eWe eBf eCnt eEb eEa
    addVec(0,0,0,32'h0,0,0, 0,0,32'h0,        0,0,0, 0,0,32'h0);
    addVec(1,1,1,32'h1000,0,0, 0,0,32'h0,     0,0,0, 1,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 1,0,32'hDEADBEEF, 1,0,0, 0,0,32'h0);
    addVec(1,1,1,32'h3000,1,0, 0,0,32'h0,     0,0,0, 1,0,32'h0);
    addVec(1,1,1,32'h3004,0,0, 0,0,32'h0,     0,1,0, 2,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 1,0,32'h11,       1,1,0, 1,0,32'h0);
    addVec(1,1,1,32'h4000,1,1, 1,0,32'h22,    1,0,0, 1,0,32'h0);
    addVec(1,1,1,32'h4004,0,0, 1,0,32'h33,    1,1,1, 1,0,32'h0);
    addVec(1,1,1,32'h4008,1,0, 1,0,32'h44,    1,0,0, 1,0,32'h0);
    addVec(1,1,1,32'h400C,1,1, 1,0,32'h45,    1,1,0, 1,0,32'h0);
    addVec(1,1,1,32'h4010,0,1, 1,0,32'h46,    1,1,1, 1,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 1,0,32'h55,       1,0,1, 0,0,32'h0);
    addVec(1,1,1,32'h2004,1,1, 0,0,32'h0,     0,0,0, 1,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 1,1,32'h0,        1,1,1, 0,1,32'h2004);
    addVec(1,0,0,32'h0,0,0, 0,0,32'h0,        0,0,0, 0,0,32'h2004);
    addVec(1,1,1,32'h2008,1,0, 0,0,32'h0,     0,0,0, 1,0,32'h2004);
    addVec(1,0,0,32'h0,0,0, 1,1,32'h0,        1,1,0, 0,0,32'h2004);
    addVec(1,0,0,32'h0,0,0, 1,1,32'h99,       0,0,0, 0,0,32'h2004);
    addVec(1,1,0,32'hAAAA,1,1, 0,0,32'h0,     0,0,0, 0,0,32'h2004);
    addVec(1,1,1,32'h5000,1,1, 0,0,32'h0,     0,0,0, 1,0,32'h2004);
    addVec(1,1,1,32'h5004,0,0, 0,0,32'h0,     0,1,1, 2,0,32'h2004);
    addVec(1,1,1,32'h6000,1,1, 0,0,32'h0,     0,1,1, 2,0,32'h2004);
    addVec(1,0,0,32'h0,0,0, 1,0,32'hA,        1,1,1, 1,0,32'h2004);
    addVec(1,0,0,32'h0,0,0, 1,0,32'hB,        1,0,0, 0,0,32'h2004);
    addVec(1,1,1,32'h7000,1,1, 0,0,32'h0,     0,0,0, 1,0,32'h2004);
    addVec(1,1,1,32'h7004,0,0, 0,0,32'h0,     0,1,1, 2,0,32'h2004);
    addVec(0,0,0,32'h0,0,0, 1,1,32'hBB,       1,1,1, 0,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 0,0,32'h0,        0,0,0, 0,0,32'h0);
    addVec(1,1,1,32'h8000,1,1, 1,1,32'hCC,    0,0,0, 1,0,32'h0);
    addVec(1,0,0,32'h0,0,0, 1,0,32'hDD,       1,1,1, 0,0,32'h0);

    applyStimulus(1'b0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rr, vecs[i].addr, vecs[i].we, vecs[i].bf,
                    vecs[i].pv, vecs[i].pe, vecs[i].rdata);
      @(negedge clk);
      checkOutput({tag, ".resp_valid"}, 32'(resp_valid_o),      32'(vecs[i].eRv));
      checkOutput({tag, ".resp_err"},   32'(resp_err_o),        32'(vecs[i].pe));
      checkOutput({tag, ".resp_rdata"}, resp_rdata_o,           vecs[i].rdata);
      checkOutput({tag, ".resp_we"},    32'(resp_we_o),         32'(vecs[i].eWe));
      checkOutput({tag, ".resp_buf"},   32'(resp_bufferable_o), 32'(vecs[i].eBf));
      @(posedge clk);
      #1;
      checkState(tag, vecs[i].eCnt, vecs[i].eEb, vecs[i].eEa);
    end

    // Back-to-back bufferable write errors: pulse stays high for two cycles and
    // the captured address follows each error in turn.
    stepCycle(1, 32'h9000, 1, 1, 0, 0, 32'h0);
    checkState("seq.grant0", 1, 0, 32'h0);
    stepCycle(1, 32'h9004, 1, 1, 0, 0, 32'h0);
    checkState("seq.grant1", 2, 0, 32'h0);
    stepCycle(0, 32'h0, 0, 0, 1, 1, 32'h0);
    checkState("seq.err0", 1, 1, 32'h9000);
    stepCycle(0, 32'h0, 0, 0, 1, 1, 32'h0);
    checkState("seq.err1", 0, 1, 32'h9004);
    stepCycle(0, 32'h0, 0, 0, 0, 0, 32'h0);
    checkState("seq.idle", 0, 0, 32'h9004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cv32e40x_data_resp_tracker.md
# cv32e40x_data_resp_tracker

Response-side companion to the data-side write buffer: observes every data OBI request accepted by the bus, records a tag per outstanding transaction, and matches in-order bus responses (rvalid) back to those tags. It forwards tagged responses to the LSU, limits outstanding transactions to DEPTH, and converts bus errors on bufferable writes into an imprecise-error pulse with captured address. It sits between the bus-side OBI response channel and the LSU, alongside the write buffer on the request channel.

## Interface
- DEPTH, 2, maximum outstanding bus transactions (≥1)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid_i  in  1  bus-side request valid (write-buffer output)
- req_ready_i  in  1  bus-side grant; valid&&ready = issued transaction
- req_trans_i  in  obi_data_req_t  issued transaction (addr, we, memtype used)
- resp_valid_i  in  1  bus rvalid
- resp_err_i  in  1  bus err, qualified by resp_valid_i
- resp_rdata_i  in  32  bus rdata
- req_block_o  out  1  1 when count==DEPTH; gates bus request valid upstream
- resp_valid_o  out  1  tagged response to LSU
- resp_err_o  out  1  forwarded err
- resp_rdata_o  out  32  forwarded rdata
- resp_we_o  out  1  head tag: write
- resp_bufferable_o  out  1  head tag: memtype[0]
- err_bufferable_o  out  1  one-cycle pulse: bus error on bufferable write
- err_addr_o  out  32  address of most recent bufferable write error
- count_o  out  $clog2(DEPTH+1)  outstanding count
- idle_o  out  1  count==0

## Operation
- Tag FIFO, DEPTH entries of {addr, we, bufferable}; read/write pointers wrap modulo DEPTH; count 0..DEPTH.
- Push: req_valid_i && req_ready_i && count<DEPTH; tag = {addr, we, memtype[0]}.
- Pop: resp_valid_i && count>0; head tag discarded after the cycle.
- Push and pop same cycle: count unchanged, both pointers advance; legal at count==DEPTH (pop frees slot but req_block_o was 1, so push only occurs if upstream violated gating; see below).
- resp_valid_o = resp_valid_i && count>0; resp_err_o, resp_rdata_o pass through; resp_we_o/resp_bufferable_o from head tag (0 when empty).
- resp_valid_i at count==0: protocol violation; ignored, no output, no pointer change; assertion fires.
- Push attempted at count==DEPTH: dropped, count unchanged; assertion fires.
- Bufferable write error: pop with resp_err_i && head.we && head.bufferable -> err_bufferable_o=1 next cycle for exactly one cycle; err_addr_o <= head.addr same edge, held until next such error.
- Errors on non-bufferable or read transactions: forwarded only via resp_err_o; no pulse.

## Timing
- Response forwarding is combinational, zero latency.
- err_bufferable_o/err_addr_o registered, one cycle after error response.
- req_block_o, count_o, idle_o are registered-state outputs, update the cycle after push/pop.
- OBI rule relied on: response never in the same cycle as its own grant; at count==0 a same-cycle push+resp_valid_i is a violation (resp ignored, push performed).
- Reset (rst_n low at clock edge, any time including mid-transaction): count=0, pointers=0, req_block_o=0, idle_o=1, count_o=0, resp_valid_o=0, resp_we_o=0, resp_bufferable_o=0, err_bufferable_o=0, err_addr_o=0; in-flight tags discarded.

## Structure
- Shared package: data_resp_tag_t {addr[31:0], we, bufferable}; reuse obi_data_req_t.
- One natural sub-module: cv32e40x_resp_tag_fifo (parameterized depth, push/pop, count, head), reused for the instruction side later.
- Assertions (no push when full, no resp when empty) in a separate SVA binding file.

## Test plan
- Reset then single read addr 0x1000 granted, rvalid next cycle rdata 0xDEADBEEF -> resp_valid_o=1, resp_we_o=0, rdata 0xDEADBEEF; count 1->0, idle_o=1.
- DEPTH=2: two grants back-to-back -> count=2, req_block_o=1; one rvalid -> req_block_o=0 next cycle.
- Simultaneous grant and rvalid at count=1, repeated 5 cycles -> count stays 1, responses carry tags in issue order across pointer wrap.
- Bufferable write to 0x2004 returns err -> err_bufferable_o high exactly one cycle after, err_addr_o=0x2004; non-bufferable write err -> resp_err_o=1, no pulse.
- rvalid with count=0 -> resp_valid_o=0, state unchanged, assertion flagged.
- rst_n low with count=2 -> next cycle count_o=0, idle_o=1, req_block_o=0, err_addr_o=0.
